mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported instruction/data memory between the Fetch stage (read-only) and the Memory stage (read/write) of the 5-stage RISC-V pipeline. Arbitrates, sequences one outstanding memory transaction at a time, returns registered responses to the owning requester, and raises per-stage stall signals for the pipeline. Sits between `fetch_cycle`/`memory_cycle` and the physical memory model.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_DM_STREAK`, 4, consecutive DM grants allowed while IF waits
- `TIMEOUT`, 64, WAIT-state cycles before an error response
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch read request, held until `if_rvalid`
- `if_addr` in AW: fetch address
- `if_rvalid` out 1: one-cycle response pulse to Fetch
- `if_rdata` out DW: instruction word, valid with `if_rvalid`
- `dm_req` in 1: data request, held until `dm_rvalid`
- `dm_we` in 1: 1 = write, 0 = read
- `dm_addr` in AW: data address
- `dm_wdata` in DW: write data
- `dm_rvalid` out 1: one-cycle response pulse to Memory stage (reads and writes)
- `dm_rdata` out DW: read data, valid with `dm_rvalid` (0 for writes)
- `resp_err` out 1: qualifies the current `*_rvalid` as a timeout
- `StallF` out 1: `if_req & ~if_rvalid`
- `StallM` out 1: `dm_req & ~dm_rvalid`
- `mem_valid` out 1: request to memory
- `mem_we`, `mem_addr`, `mem_wdata` out 1/AW/DW: registered request attributes
- `mem_ready` in 1: memory accepts when `mem_valid & mem_ready`
- `mem_rvalid` in 1: memory response, never in the acceptance cycle
- `mem_rdata` in DW: memory read data

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: arbitrate. DM wins over IF unless the streak counter equals `MAX_DM_STREAK` and `if_req` is high, in which case IF wins. Latch owner, addr, we, and wdata. If no request, stay in IDLE. `mem_rvalid` is ignored in IDLE.
- ISSUE: `mem_valid=1` with latched attributes. Go to WAIT on `mem_ready`, otherwise hold with attributes stable.
- WAIT: on `mem_rvalid`, capture `mem_rdata` (or 0 for a write) and go to RESP. The timeout counter increments each WAIT cycle. On reaching `TIMEOUT`, go to RESP with data 0 and `resp_err=1`.
- RESP: pulse the owner's `*_rvalid`, drive `*_rdata` from the capture register, then return to IDLE.
- Streak counter:
  - Increments on each DM grant while `if_req` is high.
  - Clears on any IF grant, or on a DM grant with `if_req` low.
  - Saturates at `MAX_DM_STREAK`.
- Requesters change or drop `req` in the cycle after `*_rvalid`. The arbiter never re-samples in RESP, so there is no double issue.
- A late `mem_rvalid` after a timeout is ignored (FSM is not in WAIT).
- Reset mid-transaction:
  - All state clears immediately.
  - `mem_valid` drops asynchronously.
  - An in-flight memory response is discarded.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_valid`, `mem_we`, `if_rvalid`, `dm_rvalid`, `resp_err` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - Streak and timeout counters = 0.
- Minimum latency with zero-wait memory (`mem_ready=1`, `mem_rvalid` one cycle after acceptance):
  - Request seen in cycle 0.
  - `mem_valid` in cycle 1.
  - `mem_rvalid` in cycle 2.
  - `*_rvalid` in cycle 3.
  - Next arbitration in cycle 4.
- Peak throughput is one transaction per 4 cycles.
- All outputs are registered except `StallF`/`StallM`, which are combinational from `req` and registered `rvalid`.

## Structure
- Shared `riscv_pkg` holds:
  - FSM state encodings (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`).
  - Owner encodings (`OWN_IF`, `OWN_DM`).
- One sub-module, `arb_sat_counter`: parameterised saturating counter with clear/increment. Instantiated twice, for streak and for timeout.

## Test plan
- IF-only read: `if_req=1`, `if_addr=0x100`, memory returns `0x00500093` → `if_rvalid` in cycle 3 with `if_rdata=0x00500093`; `StallF` high in cycles 0–2.
- Simultaneous `if_req` (`0x104`) and `dm_req` read (`0x2000`) → DM granted first; `dm_rvalid` in cycle 3, `if_rvalid` in cycle 7.
- DM write `dm_addr=0x2004`, `dm_wdata=0xDEADBEEF` → `mem_we=1`, `mem_wdata=0xDEADBEEF`; `dm_rvalid` with `dm_rdata=0`.
- Continuous `dm_req` with `if_req` held, `MAX_DM_STREAK=4` → 4 DM grants, then 1 IF grant, then the streak counter resets.
- Memory never asserts `mem_rvalid`, `TIMEOUT=64` → owner's `*_rvalid` and `resp_err=1` in the cycle after the 64th WAIT cycle, data 0; a later `mem_rvalid` is ignored.
- `rst` low during WAIT → `mem_valid`=0 and state IDLE immediately; after release, a new `if_req` completes normally in 4 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline memory-port arbiter: FSM states and transaction owners.
package riscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    // Bits needed to hold counts 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MaxVal)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between Fetch (read-only) and Memory stage (read/write),
// one outstanding transaction at a time, with registered responses and per-stage stalls.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic          clk,
    input  logic          rst,
    // Fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // Memory-stage port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          resp_err,
    // Pipeline stalls
    output logic          StallF,
    output logic          StallM,
    // Physical memory
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned SW = cnt_width(MAX_DM_STREAK);
    localparam int unsigned TW = cnt_width(TIMEOUT);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q;

    logic          grant_if, grant_dm, grant;
    logic          streak_full, streak_inc, streak_clr;
    logic          tmo_hit, tmo_inc, tmo_clr;
    logic          resp_fire;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] streak_cnt;
    logic [TW-1:0] tmo_cnt;

    assign streak_full = (streak_cnt == SW'(MAX_DM_STREAK));
    // The count still reads TIMEOUT-1 during the TIMEOUT-th WAIT cycle.
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (dm_req && !(streak_full && if_req)) begin
                    grant_dm = 1'b1;
                    state_d  = ARB_ISSUE;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid || tmo_hit) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant      = grant_if | grant_dm;
    assign streak_inc = grant_dm & if_req;
    assign streak_clr = grant_if | (grant_dm & ~if_req);
    assign tmo_inc    = (state_q == ARB_WAIT);
    assign tmo_clr    = (state_q != ARB_WAIT);
    assign resp_fire  = (state_q == ARB_WAIT) && (mem_rvalid || tmo_hit);
    // Writes and timeouts return zero data.
    assign cap_data   = (mem_rvalid && !mem_we) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_IF;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            resp_err  <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            resp_err  <= 1'b0;

            if (grant) begin
                owner_q   <= grant_dm ? OWN_DM : OWN_IF;
                mem_valid <= 1'b1;
                mem_we    <= grant_dm & dm_we;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_wdata <= (grant_dm && dm_we) ? dm_wdata : '0;
            end

            if ((state_q == ARB_ISSUE) && mem_ready) begin
                mem_valid <= 1'b0;
            end

            if (resp_fire) begin
                resp_err <= ~mem_rvalid;
                if (owner_q == OWN_DM) begin
                    dm_rvalid <= 1'b1;
                    dm_rdata  <= cap_data;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= cap_data;
                end
            end
        end
    end

    arb_sat_counter #(
        .MAX (MAX_DM_STREAK),
        .W   (SW)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (streak_clr),
        .inc   (streak_inc),
        .count (streak_cnt)
    );

    arb_sat_counter #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmo_clr),
        .inc   (tmo_inc),
        .count (tmo_cnt)
    );

    assign StallF = if_req & ~if_rvalid;
    assign StallM = dm_req & ~dm_rvalid;

endmodule
